// File: rtl/cpu_bus_if.sv
// CPU-side bus bundle between the 65C02 core/board glue and cpu_bus_ctrl.
// RDY handshake: the CPU samples RDY on each cpu_en tick and advances only when it is 1; it holds cpu_AB/cpu_WE stable while RDY is 0.
interface cpu_bus_if #(
  parameter int NUM_IRQ = 4,
  parameter int IRQ_IDW = 2
);
  logic                cpu_en;
  logic                phi2;
  logic                H1n;
  logic [15:0]         cpu_AB;
  logic                cpu_WE;
  logic [NUM_IRQ-1:0]  irq_ck;
  logic [NUM_IRQ-1:0]  INTACKn;
  logic [NUM_IRQ-1:0]  irq_mask;
  logic                IRQ;
  logic [NUM_IRQ-1:0]  irq_pending;
  logic [IRQ_IDW-1:0]  irq_id;
  logic                RDY;
  logic                BRWn;
  logic                WRITEn;
  logic                DRWR;

  modport master (
    output cpu_en, phi2, H1n, cpu_AB, cpu_WE, irq_ck, INTACKn, irq_mask,
    input  IRQ, irq_pending, irq_id, RDY, BRWn, WRITEn, DRWR
  );

  modport slave (
    input  cpu_en, phi2, H1n, cpu_AB, cpu_WE, irq_ck, INTACKn, irq_mask,
    output IRQ, irq_pending, irq_id, RDY, BRWn, WRITEn, DRWR
  );
endinterface

// File: rtl/cpu_bus_ctrl.sv
// CPU bus controller: edge-latched maskable IRQs with priority ID, RDY wait-state
// sequencer for a slow address window, and RDY-qualified write strobes.
module cpu_bus_ctrl #(
  parameter int          NUM_IRQ     = 4,
  parameter int          IRQ_IDW     = 2,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] WAIT_BASE   = 16'h9000,
  parameter logic [15:0] WAIT_MASK   = 16'hF000,
  parameter logic [15:0] RAM_LIMIT   = 16'h8000
) (
  input  logic         clk,
  input  logic         RESETn,
  cpu_bus_if.slave     bus,
  output logic [1:0]   fsm_state
);

  localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t WAIT_LAST = cnt_t'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state;
  cnt_t                cnt;
  logic [NUM_IRQ-1:0]  irq_ck_d;
  logic [NUM_IRQ-1:0]  pending;
  logic [NUM_IRQ-1:0]  irq_edge;
  logic [NUM_IRQ-1:0]  enabled;
  logic                irq_q;
  logic                match;
  logic                fsm_rdy;
  logic                rdy;
  logic                wr;

  // Interrupt latching: acknowledge is applied last so it beats a same-clk edge.
  assign irq_edge = bus.irq_ck & ~irq_ck_d;
  assign enabled  = pending & bus.irq_mask;

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      irq_ck_d <= '0;
      pending  <= '0;
      irq_q    <= 1'b0;
    end else begin
      irq_ck_d <= bus.irq_ck;
      pending  <= (pending | irq_edge) & bus.INTACKn;
      irq_q    <= |enabled;
    end
  end

  always_comb begin
    logic found;
    found      = 1'b0;
    bus.irq_id = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (enabled[i] && !found) begin
        bus.irq_id = IRQ_IDW'(i);
        found      = 1'b1;
      end
    end
  end

  assign bus.IRQ         = irq_q;
  assign bus.irq_pending = pending;

  assign match = ((bus.cpu_AB & WAIT_MASK) == WAIT_BASE) && (WAIT_CYCLES != 0);

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (bus.cpu_en) begin
      case (state)
        IDLE: begin
          if (match) begin
            if (WAIT_CYCLES == 1) begin
              state <= DONE;
            end else begin
              state <= STALL;
              cnt   <= cnt_t'(1);
            end
          end
        end
        STALL: begin
          cnt <= cnt + cnt_t'(1);
          if (cnt + cnt_t'(1) == WAIT_LAST) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // In IDLE the first slow-window tick already stalls, so RDY follows the address directly.
  always_comb begin
    fsm_rdy = 1'b1;
    case (state)
      IDLE:    fsm_rdy = ~match;
      STALL:   fsm_rdy = 1'b0;
      DONE:    fsm_rdy = 1'b1;
      default: fsm_rdy = 1'b1;
    endcase
  end

  assign rdy       = ~RESETn | fsm_rdy;
  assign bus.RDY   = rdy;
  assign fsm_state = state;

  assign wr         = bus.cpu_WE & bus.phi2 & rdy;
  assign bus.BRWn   = ~bus.cpu_WE;
  assign bus.WRITEn = ~(wr & ~bus.H1n);
  assign bus.DRWR   = wr & (bus.cpu_AB < RAM_LIMIT);

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Directed bench for cpu_bus_ctrl: IRQ latching/priority/ack, wait states, strobes, reset mid-stall.
module tb_cpu_bus_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cpu_bus_if #(.NUM_IRQ(4), .IRQ_IDW(2)) bus ();
  cpu_bus_if #(.NUM_IRQ(4), .IRQ_IDW(2)) bus0 ();
  logic [1:0] fsm_state;
  logic [1:0] fsm_state0;

  cpu_bus_ctrl #(
    .NUM_IRQ(4), .IRQ_IDW(2), .WAIT_CYCLES(2),
    .WAIT_BASE(16'h9000), .WAIT_MASK(16'hF000), .RAM_LIMIT(16'h8000)
  ) dut (
    .clk(clk), .RESETn(rst_n), .bus(bus), .fsm_state(fsm_state)
  );

  cpu_bus_ctrl #(
    .NUM_IRQ(4), .IRQ_IDW(2), .WAIT_CYCLES(0),
    .WAIT_BASE(16'h9000), .WAIT_MASK(16'hF000), .RAM_LIMIT(16'h8000)
  ) dut0 (
    .clk(clk), .RESETn(rst_n), .bus(bus0), .fsm_state(fsm_state0)
  );

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // One CPU tick: returns {RDY, WRITEn, DRWR} as seen just before the ticking edge.
  task automatic cpu_tick(output logic [2:0] s);
    @(negedge clk);
    bus.cpu_en = 1'b1;
    #1;
    s = {bus.RDY, bus.WRITEn, bus.DRWR};
    @(negedge clk);
    bus.cpu_en = 1'b0;
    #1;
  endtask

  task automatic drain(input string tag);
    logic [2:0] s;
    logic [2:0] e;
    while (exp_q.size() > 0) begin
      cpu_tick(s);
      e = exp_q.pop_front();
      check(tag, 16'(s), 16'(e));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] s;
    rst_n        = 1'b0;
    bus.cpu_en   = 1'b0;  bus.phi2    = 1'b0;  bus.H1n      = 1'b1;
    bus.cpu_AB   = 16'h0; bus.cpu_WE  = 1'b0;  bus.irq_ck   = '0;
    bus.INTACKn  = '1;    bus.irq_mask = '0;
    bus0.cpu_en  = 1'b1;  bus0.phi2   = 1'b0;  bus0.H1n     = 1'b1;
    bus0.cpu_AB  = 16'h9000; bus0.cpu_WE = 1'b0; bus0.irq_ck = '0;
    bus0.INTACKn = '1;    bus0.irq_mask = '0;

    repeat (3) step();
    check("rst_irq", 16'(bus.IRQ), 16'h0);
    check("rst_pend", 16'(bus.irq_pending), 16'h0);
    check("rst_id", 16'(bus.irq_id), 16'h0);
    check("rst_rdy", 16'(bus.RDY), 16'h1);
    check("rst_state", 16'(fsm_state), 16'h0);
    rst_n = 1'b1;
    step();

    // Priority and acknowledge
    bus.irq_mask = 4'hF;
    bus.irq_ck   = 4'b0110;
    step();
    check("prio_pend", 16'(bus.irq_pending), 16'h6);
    check("prio_irq_lat", 16'(bus.IRQ), 16'h0);
    check("prio_id", 16'(bus.irq_id), 16'h1);
    step();
    check("prio_irq", 16'(bus.IRQ), 16'h1);
    bus.INTACKn = 4'b1101;
    step();
    bus.INTACKn = '1;
    check("ack1_pend", 16'(bus.irq_pending), 16'h4);
    check("ack1_id", 16'(bus.irq_id), 16'h2);
    step();
    check("ack1_irq", 16'(bus.IRQ), 16'h1);
    bus.INTACKn = 4'b1011;
    step();
    bus.INTACKn = '1;
    check("ack2_pend", 16'(bus.irq_pending), 16'h0);
    check("ack2_irq_lat", 16'(bus.IRQ), 16'h1);
    step();
    check("ack2_irq", 16'(bus.IRQ), 16'h0);

    // Ack beats a simultaneous edge
    bus.irq_ck  = 4'b1110;
    bus.INTACKn = 4'b0111;
    step();
    bus.INTACKn = '1;
    check("coll_pend", 16'(bus.irq_pending), 16'h0);
    step();
    check("coll_pend2", 16'(bus.irq_pending), 16'h0);

    // Masked source still latches
    bus.irq_ck   = '0;
    bus.irq_mask = 4'b1110;
    step();
    bus.irq_ck = 4'b0001;
    step();
    check("mask_pend", 16'(bus.irq_pending), 16'h1);
    check("mask_id", 16'(bus.irq_id), 16'h0);
    step();
    check("mask_irq", 16'(bus.IRQ), 16'h0);
    bus.irq_mask = 4'hF;
    #1;
    check("unmask_irq_lat", 16'(bus.IRQ), 16'h0);
    step();
    check("unmask_irq", 16'(bus.IRQ), 16'h1);
    bus.INTACKn = 4'b1110;
    step();
    bus.INTACKn = '1;
    bus.irq_ck  = '0;
    step();
    check("clr0_pend", 16'(bus.irq_pending), 16'h0);
    check("clr0_irq", 16'(bus.IRQ), 16'h0);

    // Wait states on reads
    bus.cpu_AB = 16'h9123;
    bus.cpu_WE = 1'b0;
    exp_q.push_back(3'b010); exp_q.push_back(3'b010); exp_q.push_back(3'b110);
    drain("rd_slow");
    check("rd_slow_idle", 16'(fsm_state), 16'h0);
    bus.cpu_AB = 16'h1234;
    repeat (3) exp_q.push_back(3'b110);
    drain("rd_fast");
    bus.cpu_AB = 16'h9000;
    repeat (2) begin
      exp_q.push_back(3'b010); exp_q.push_back(3'b010); exp_q.push_back(3'b110);
    end
    drain("rd_b2b");
    bus.cpu_AB = 16'h0000;

    // Write strobes
    bus.cpu_WE = 1'b1;
    bus.phi2   = 1'b1;
    bus.H1n    = 1'b0;
    bus.cpu_AB = 16'h0100;
    #1;
    check("wr_ram_writen", 16'(bus.WRITEn), 16'h0);
    check("wr_ram_drwr", 16'(bus.DRWR), 16'h1);
    check("wr_ram_brwn", 16'(bus.BRWn), 16'h0);
    bus.cpu_AB = 16'hC000;
    #1;
    check("wr_hi_writen", 16'(bus.WRITEn), 16'h0);
    check("wr_hi_drwr", 16'(bus.DRWR), 16'h0);
    bus.H1n = 1'b1;
    #1;
    check("wr_h1_writen", 16'(bus.WRITEn), 16'h1);
    bus.H1n    = 1'b0;
    bus.cpu_AB = 16'h9000;
    #1;
    check("wr_slow_early", 16'(bus.WRITEn), 16'h1);
    exp_q.push_back(3'b010); exp_q.push_back(3'b010); exp_q.push_back(3'b100);
    drain("wr_slow");
    bus.cpu_AB = 16'h0000;
    bus.cpu_WE = 1'b0;
    bus.phi2   = 1'b0;
    bus.H1n    = 1'b1;

    // Wait states disabled build
    repeat (4) begin
      step();
      check("w0_rdy", 16'(bus0.RDY), 16'h1);
      check("w0_state", 16'(fsm_state0), 16'h0);
    end

    // Reset in the middle of a stall
    bus.irq_ck = 4'b0101;
    step();
    check("pre_rst_pend", 16'(bus.irq_pending), 16'h5);
    step();
    check("pre_rst_irq", 16'(bus.IRQ), 16'h1);
    bus.cpu_AB = 16'h9000;
    cpu_tick(s);
    check("pre_rst_rdy", 16'(s[2]), 16'h0);
    check("pre_rst_state", 16'(fsm_state), 16'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_irq", 16'(bus.IRQ), 16'h0);
    check("mid_rst_pend", 16'(bus.irq_pending), 16'h0);
    check("mid_rst_rdy", 16'(bus.RDY), 16'h1);
    check("mid_rst_state", 16'(fsm_state), 16'h0);
    bus.irq_ck = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_pend", 16'(bus.irq_pending), 16'h0);
    exp_q.push_back(3'b010); exp_q.push_back(3'b010); exp_q.push_back(3'b110);
    drain("post_rst_slow");
    bus.cpu_AB = 16'h0000;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
